// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO drain-side stream reader.
package fifo_stream_reader_pkg;

    // Controller states, kept as plain constants so legacy code can compare against them.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BURST = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO and emits counted bursts on a registered valid/ready stream.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] fifo_data_out,
    input  logic             fifo_data_valid,
    output logic             fifo_ren,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic             accept;
    logic             last_pop;

    assign accept = m_valid & m_ready;

    // Pop only while beats remain, the FIFO has a word, and the output register can take it.
    assign fifo_ren = (state_q == ST_BURST) & (issued_q != len_q) & fifo_data_valid &
                      (~m_valid | m_ready);

    // len_q is never zero in BURST, so the decrement cannot wrap when it matters.
    assign last_pop = (issued_q == (len_q - LEN_W'(1)));

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d  = ST_BURST;
                        len_d    = burst_len;
                        issued_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BURST: begin
                if (fifo_ren) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (accept & m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and burst counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
        end
    end

    // Output register: reloads on a pop (even while the current beat is accepted), else empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (fifo_ren) begin
            m_valid <= 1'b1;
            m_data  <= fifo_data_out;
            m_last  <= last_pop;
        end else if (accept) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural show-ahead FIFO in front of it.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] burst_len;
    logic       busy;
    logic       done;
    logic [7:0] fifo_data_out;
    logic       fifo_data_valid;
    logic       fifo_ren;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;

    int passed = 0;
    int total  = 0;

    // Behavioural FIFO: the initial block only pushes, the pop process only advances rd_ptr.
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign fifo_data_valid = (wr_ptr != rd_ptr);
    assign fifo_data_out   = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_ren && fifo_data_valid) rd_ptr <= rd_ptr + 1;
    end

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH (8),
        .LEN_W (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .burst_len       (burst_len),
        .busy            (busy),
        .done            (done),
        .fifo_data_out   (fifo_data_out),
        .fifo_data_valid (fifo_data_valid),
        .fifo_ren        (fifo_ren),
        .m_valid         (m_valid),
        .m_data          (m_data),
        .m_last          (m_last),
        .m_ready         (m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks one beat at the current negedge: valid, data, last, and the pop request.
    task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic ren);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, m_data}, {24'd0, d});
        chk({tag, "_last"}, {31'd0, m_last}, {31'd0, l});
        chk({tag, "_ren"}, {31'd0, fifo_ren}, {31'd0, ren});
    endtask

    // Pops must never be issued against an empty FIFO.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fifo_ren === 1'b1) begin
            chk("no_underflow", {31'd0, fifo_data_valid}, 32'd1);
        end
    end

    initial begin
        // 1: reset while the FIFO holds four words
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = 8'd0;
        m_ready   = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ren", {31'd0, fifo_ren}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_ren", {31'd0, fifo_ren}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 2: full-throughput burst of 4
        start = 1'b1; burst_len = 8'd4;
        step();
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_ren0", {31'd0, fifo_ren}, 32'd1);
        chk("t2_valid0", {31'd0, m_valid}, 32'd0);
        start = 1'b0;
        step(); beat("t2_a", 8'hA1, 1'b0, 1'b1);
        step(); beat("t2_b", 8'hA2, 1'b0, 1'b1);
        step(); beat("t2_c", 8'hA3, 1'b0, 1'b1);
        step(); beat("t2_d", 8'hA4, 1'b1, 1'b0);
        step();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_valid_off", {31'd0, m_valid}, 32'd0);
        step();
        chk("t2_done_off", {31'd0, done}, 32'd0);
        chk("t2_busy_off", {31'd0, busy}, 32'd0);
        chk("t2_fifo_empty", {31'd0, fifo_data_valid}, 32'd0);

        // 3: burst of 3 under backpressure, fourth word stays behind
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        start = 1'b1; burst_len = 8'd3;
        step();
        chk("t3_ren0", {31'd0, fifo_ren}, 32'd1);
        start = 1'b0; m_ready = 1'b0;
        step(); beat("t3_a_stall0", 8'h31, 1'b0, 1'b0);
        step(); beat("t3_a_stall1", 8'h31, 1'b0, 1'b0);
        m_ready = 1'b1;
        step(); beat("t3_b", 8'h32, 1'b0, 1'b1);
        m_ready = 1'b0;
        step(); beat("t3_b_stall0", 8'h32, 1'b0, 1'b0);
        step(); beat("t3_b_stall1", 8'h32, 1'b0, 1'b0);
        m_ready = 1'b1;
        step(); beat("t3_c", 8'h33, 1'b1, 1'b0);
        m_ready = 1'b0;
        step(); beat("t3_c_stall", 8'h33, 1'b1, 1'b0);
        chk("t3_not_done", {31'd0, done}, 32'd0);
        m_ready = 1'b1;
        step();
        chk("t3_done", {31'd0, done}, 32'd1);
        step();
        chk("t3_left", wr_ptr - rd_ptr, 32'd1);
        chk("t3_head", {24'd0, fifo_data_out}, 32'h34);

        // single-beat burst drains the leftover word
        start = 1'b1; burst_len = 8'd1;
        step();
        start = 1'b0;
        step(); beat("t3_single", 8'h34, 1'b1, 1'b0);
        step();
        chk("t3_single_done", {31'd0, done}, 32'd1);
        step();

        // 4: FIFO empty at start, words trickle in
        start = 1'b1; burst_len = 8'd2;
        step();
        start = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_ren_c1", {31'd0, fifo_ren}, 32'd0);
        step(); chk("t4_ren_c2", {31'd0, fifo_ren}, 32'd0);
        step(); chk("t4_ren_c3", {31'd0, fifo_ren}, 32'd0);
        step(); chk("t4_valid_c4", {31'd0, m_valid}, 32'd0);
        push(8'h41);
        step(); beat("t4_a", 8'h41, 1'b0, 1'b0);
        step(); chk("t4_gap_valid", {31'd0, m_valid}, 32'd0);
        step(); chk("t4_gap_ren", {31'd0, fifo_ren}, 32'd0);
        step(); chk("t4_gap_busy", {31'd0, busy}, 32'd1);
        push(8'h42);
        step(); beat("t4_b", 8'h42, 1'b1, 1'b0);
        step(); chk("t4_done", {31'd0, done}, 32'd1);
        step();

        // 5: zero-length burst, then a start during BURST is ignored
        start = 1'b1; burst_len = 8'd0;
        step();
        start = 1'b0;
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_ren", {31'd0, fifo_ren}, 32'd0);
        chk("t5_valid", {31'd0, m_valid}, 32'd0);
        step();
        chk("t5_done_off", {31'd0, done}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        push(8'h51); push(8'h52); push(8'h53);
        start = 1'b1; burst_len = 8'd2;
        step();
        burst_len = 8'd5;
        step(); beat("t5_a", 8'h51, 1'b0, 1'b1);
        start = 1'b0;
        step(); beat("t5_b", 8'h52, 1'b1, 1'b0);
        step(); chk("t5b_done", {31'd0, done}, 32'd1);
        step();
        chk("t5_left", wr_ptr - rd_ptr, 32'd1);

        // 6: reset after two of five beats, then a fresh burst of 3
        push(8'h54); push(8'h55); push(8'h56); push(8'h57);
        push(8'h58); push(8'h59); push(8'h5A);
        start = 1'b1; burst_len = 8'd5;
        step();
        start = 1'b0;
        step(); beat("t6_a", 8'h53, 1'b0, 1'b1);
        step(); beat("t6_b", 8'h54, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, m_data}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_ren", {31'd0, fifo_ren}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        step(); beat("t6_c", 8'h55, 1'b0, 1'b1);
        step(); beat("t6_d", 8'h56, 1'b0, 1'b1);
        step(); beat("t6_e", 8'h57, 1'b1, 1'b0);
        step(); chk("t6_done", {31'd0, done}, 32'd1);
        step();
        chk("t6_left", wr_ptr - rd_ptr, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain side of the FIFO block. Pops words through the FIFO's show-ahead read interface: data_out is valid whenever data_valid is high, and a word is consumed by ren.
- Emits the words as counted bursts on a registered valid/ready stream with a last flag.
- Sits between buffering FIFOs and downstream consumers (PE arrays, writeback); a controller issues one start per burst.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- LEN_W, 8, width of the burst length field; max burst is 2^LEN_W-1 beats.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  burst request; sampled only in IDLE
- burst_len  input  LEN_W  beats in the burst; sampled with start
- busy  output  1  high in any state other than IDLE
- done  output  1  single-cycle pulse at burst completion
- fifo_data_out  input  WIDTH  FIFO head word (show-ahead)
- fifo_data_valid  input  1  FIFO non-empty
- fifo_ren  output  1  pop request to the FIFO
- m_valid  output  1  output beat valid (registered)
- m_data  output  WIDTH  output beat data (registered)
- m_last  output  1  final beat of the burst (registered)
- m_ready  input  1  downstream accept

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset values:
  - state = IDLE
  - busy, done, fifo_ren, m_valid, m_last = 0
  - m_data = 0
  - counters = 0
- FSM states: IDLE, BURST, DONE.
  - IDLE -> BURST on start when burst_len != 0. Latch len_q = burst_len; set issued = 0.
  - IDLE -> DONE on start when burst_len == 0. No beats are emitted and fifo_ren is never asserted.
  - BURST -> DONE in the cycle m_valid & m_ready & m_last is true.
  - DONE -> IDLE unconditionally after one cycle. done = 1 only while in DONE.
  - start outside IDLE is ignored; burst_len is not re-sampled.
- Pop rule (combinational):
  - fifo_ren = (state == BURST) & (issued != len_q) & fifo_data_valid & (!m_valid | m_ready).
  - fifo_ren is never asserted when the FIFO is empty, so no underflow.
- On a pop:
  - m_data <= fifo_data_out, m_valid <= 1, issued <= issued + 1.
  - m_last <= (issued == len_q - 1).
- When m_valid & m_ready and there is no pop in the same cycle: m_valid <= 0, m_last <= 0.
- Pop and accept in the same cycle: the output register reloads, giving full throughput of one beat per cycle with no bubble.
- Latency: first m_valid appears 1 cycle after the first fifo_ren; start to first fifo_ren is 1 cycle when the FIFO is non-empty.
- Backpressure:
  - With m_valid = 1 and m_ready = 0, m_data and m_last are held stable and fifo_ren = 0.
  - No beat is dropped or duplicated.
- FIFO running dry mid-burst: the block stalls in BURST with no timeout, and resumes when fifo_data_valid returns.
- Width rules: issued and len_q are LEN_W bits; issued never exceeds len_q, so there is no wrap. len_q - 1 is evaluated only when len_q != 0.
- Exactly len_q beats are popped per burst. Words beyond the burst stay in the FIFO for the next start.
- Reset mid-burst clears everything immediately. FIFO words already popped are lost; the caller re-issues the burst.

Decomposition:
- Shared package: state enum type (IDLE, BURST, DONE).
- No sub-module is needed. The output register is inline; a separate skid stage is unnecessary because the pop rule already uses m_ready.

Test Plan:
1. Reset with FIFO holding 4 words -> all outputs 0, fifo_ren = 0 until start.
2. FIFO holds A,B,C,D; start with burst_len = 4; m_ready = 1 -> fifo_ren high for 4 consecutive cycles; m_data = A,B,C,D on consecutive cycles; m_last only with D; done pulses 1 cycle after D is accepted; busy then drops.
3. burst_len = 3; m_ready toggles 1,0,0,1,... -> beats stay stable while stalled; exactly 3 pops; no duplicate or lost beat; the 4th FIFO word remains.
4. FIFO empty at start, burst_len = 2; push 1 word at cycle 5 and 1 word at cycle 9 -> fifo_ren only on cycles where fifo_data_valid = 1; 2 beats out; m_last on the second.
5. start with burst_len = 0 -> done pulses 1 cycle later; zero fifo_ren and zero m_valid; a start pulse during BURST is ignored and len is unchanged.
6. Assert rst_n low mid-burst after 2 of 5 beats -> outputs return to reset values immediately; a fresh start with burst_len = 3 then emits the next 3 FIFO words correctly.
